// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, idle-high line; oversampled by CLKS_PER_BIT.
// Latency: data_valid rises 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT edges after the edge that launched the start bit.
// Backpressure: none; data_valid/frame_err are single-cycle pulses and data_out holds until the next good byte.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   rx_in       asynchronous serial line (idle high)
//   data_out    last correctly received byte
//   data_valid  one-cycle pulse, data_out updated
//   frame_err   one-cycle pulse, stop bit sampled low
//   busy        receiver is not idle
//
// Latency breakdown: 2 synchronizer flops, 1 IDLE detection edge,
// CLKS_PER_BIT/2 to the start-bit midpoint, 9*CLKS_PER_BIT to the stop-bit
// midpoint. The pulse itself comes from a register, so it is visible in the
// cycle after that last sampling edge.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          dv_q, dv_d;
  logic          fe_q, fe_d;
  logic          rxs;

  assign rxs = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rxs) begin
          state_d = START;
        end
      end

      // Re-check the line at the start-bit midpoint so a short glitch is dropped.
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end

      // Counter restarts at the start-bit midpoint, so every sample lands mid-bit.
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d          = '0;
          shift_d[bit_q] = rxs;
          bit_d          = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rxs) begin
            data_d  = shift_q;
            dv_d    = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end

      // A held break must not be mistaken for a stream of start bits.
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rxs) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames plus randomized frames scored against a byte queue.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Pulse monitor: collects received bytes and protocol violations.
  int         dv_cnt = 0;
  int         fe_cnt = 0;
  int         viol   = 0;
  logic [7:0] rx_q[$];
  logic       prev_dv  = 1'b0;
  logic       prev_fe  = 1'b0;
  logic       prev_rst = 1'b1;
  logic [7:0] prev_do  = 8'h00;

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      dv_cnt++;
      rx_q.push_back(data_out);
    end
    if (frame_err === 1'b1) fe_cnt++;
    if (data_valid === 1'b1 && frame_err === 1'b1) viol++;
    if ((data_valid === 1'b1 && prev_dv) || (frame_err === 1'b1 && prev_fe)) viol++;
    if (data_out !== prev_do && data_valid !== 1'b1 && !rst && !prev_rst) viol++;
    prev_dv  = (data_valid === 1'b1);
    prev_fe  = (frame_err === 1'b1);
    prev_rst = rst;
    prev_do  = data_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is positioned #1 after a rising edge; each bit lasts CPB cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_in = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int         lat;
  int         dv0, fe0, base;
  logic [7:0] hold;
  logic [7:0] exp_q[$];
  int         fe_exp;
  logic [7:0] rb;
  logic       bad;

  initial begin
    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", data_out, 8'h00);
    check("reset_data_valid", data_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst = 1'b0;
    idle(CPB);

    // Single 0xAA frame with exact latency measurement.
    dv0 = dv_cnt; fe0 = fe_cnt; lat = 0;
    fork
      send_frame(8'hAA, 1'b1);
      begin
        while (lat < 400 && data_valid !== 1'b1) begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
    join
    idle(2 * CPB);
    check("aa_latency", lat, 2 + CPB / 2 + 9 * CPB + 1);
    check("aa_pulses", dv_cnt - dv0, 1);
    check("aa_data", data_out, 8'hAA);
    check("aa_no_ferr", fe_cnt - fe0, 0);

    // Back-to-back 0x55, 0xF0 with no idle gap.
    dv0 = dv_cnt; base = rx_q.size();
    send_frame(8'h55, 1'b1);
    send_frame(8'hF0, 1'b1);
    idle(2 * CPB);
    check("b2b_pulses", dv_cnt - dv0, 2);
    check("b2b_first", (rx_q.size() > base) ? rx_q[base] : 8'hxx, 8'h55);
    check("b2b_second", (rx_q.size() > base + 1) ? rx_q[base+1] : 8'hxx, 8'hF0);

    // Start-bit glitch of 3 cycles.
    dv0 = dv_cnt; fe0 = fe_cnt; hold = data_out;
    rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("glitch_busy_high", busy, 1'b1);
    idle(2 * CPB);
    check("glitch_busy_low", busy, 1'b0);
    check("glitch_no_dv", dv_cnt - dv0, 0);
    check("glitch_no_fe", fe_cnt - fe0, 0);
    check("glitch_data_hold", data_out, hold);

    // Bad stop bit then break held 40 bit times.
    dv0 = dv_cnt; fe0 = fe_cnt; hold = data_out;
    send_frame(8'h3C, 1'b0);
    repeat (40 * CPB) @(posedge clk);
    #1;
    check("break_busy_held", busy, 1'b1);
    check("break_one_ferr", fe_cnt - fe0, 1);
    check("break_no_dv", dv_cnt - dv0, 0);
    check("break_data_hold", data_out, hold);
    idle(4);
    check("break_busy_low", busy, 1'b0);
    idle(CPB);
    send_frame(8'h81, 1'b1);
    idle(2 * CPB);
    check("after_break_data", data_out, 8'h81);
    check("after_break_pulses", dv_cnt - dv0, 1);

    // Reset during data bit 4 of 0x99, held until the frame is over.
    dv0 = dv_cnt; fe0 = fe_cnt;
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (5 * CPB + CPB / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5 * CPB) @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    idle(2 * CPB);
    check("rst_no_dv", dv_cnt - dv0, 0);
    check("rst_no_fe", fe_cnt - fe0, 0);
    check("rst_data_zero", data_out, 8'h00);
    check("rst_busy_low", busy, 1'b0);
    send_frame(8'h42, 1'b1);
    idle(2 * CPB);
    check("rst_next_data", data_out, 8'h42);

    // Transmitter-style frame of 8'b10101010 at the matching bit rate.
    dv0 = dv_cnt;
    send_frame(8'b10101010, 1'b1);
    idle(2 * CPB);
    check("loop_data", data_out, 8'hAA);
    check("loop_pulses", dv_cnt - dv0, 1);

    // Randomized frames, some with a bad stop bit; model is a queue of good bytes.
    rx_q.delete();
    fe0    = fe_cnt;
    fe_exp = 0;
    for (int i = 0; i < 24; i++) begin
      rb  = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      send_frame(rb, !bad);
      if (bad) begin
        fe_exp++;
        idle(CPB + $urandom_range(0, CPB));
      end else begin
        exp_q.push_back(rb);
        idle($urandom_range(0, 2 * CPB));
      end
    end
    idle(3 * CPB);
    check("rand_count", rx_q.size(), exp_q.size());
    check("rand_ferr", fe_cnt - fe0, fe_exp);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("rand_byte_%0d", i), (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
    end
    if (exp_q.size() > 0) check("rand_last_data", data_out, exp_q[exp_q.size()-1]);
    check("protocol_violations", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 4..65535.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rx_in  input  1  serial line from the UART transmitter (out_tx); idle high, 8N1, LSB first.
REQ-005 data_out  output  8  last correctly received byte.
REQ-006 data_valid  output  1  one-cycle pulse: data_out updated this cycle.
REQ-007 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-008 busy  output  1  high in any state other than IDLE.

Function
REQ-009 rx_in SHALL pass through a 2-flop synchronizer, reset to 1; all decisions use the synchronized value (rxs).
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH; bit counter 3 bits; cycle counter wide enough for CLKS_PER_BIT-1.
REQ-011 IDLE: on rxs==0 -> START, cycle counter cleared.
REQ-012 START: at count CLKS_PER_BIT/2-1 (integer division), rxs==1 -> IDLE (glitch, no output); rxs==0 -> DATA, counters cleared.
REQ-013 DATA: at each count CLKS_PER_BIT-1, sample rxs into shift register bit[bit_idx], bit_idx from 0 to 7; counter clears; after bit 7 -> STOP.
REQ-014 STOP: at count CLKS_PER_BIT-1, rxs==1 -> data_out <= shift register, data_valid=1 for one cycle, -> IDLE.
REQ-015 STOP: at count CLKS_PER_BIT-1, rxs==0 -> frame_err=1 for one cycle, data_out unchanged, -> WAIT_HIGH.
REQ-016 WAIT_HIGH: stay until rxs==1, then -> IDLE; no start detection while low (break held low yields exactly one frame_err).
REQ-017 data_valid and frame_err SHALL never be high in the same cycle and are never high for more than one consecutive cycle.
REQ-018 Latency: data_valid SHALL assert 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (plus one register stage, fixed and documented in RTL) after rx_in first falls; verification checks the exact value against the implementation constant, tolerance 0.
REQ-019 Back-to-back frames: a start bit beginning immediately after the stop-bit midpoint SHALL be accepted without loss.
REQ-020 data_out SHALL hold its value between data_valid pulses.

Reset
REQ-021 rst high at a clock edge SHALL force: state IDLE, counters 0, shift register 0, synchronizer flops 1, data_out 8'h00, data_valid 0, frame_err 0, busy 0.
REQ-022 Reset mid-frame SHALL abort the frame without any data_valid or frame_err pulse; reception resumes at the next falling edge of rx_in after rst deasserts.
REQ-023 rst has priority over every other event in the same cycle.

Verification
REQ-024 Frame 0xAA (CLKS_PER_BIT=16) driven after reset -> one data_valid pulse, data_out=8'hAA, frame_err never high.
REQ-025 Frames 0x55 then 0xF0 back-to-back with no idle gap -> two data_valid pulses, data_out 8'h55 then 8'hF0.
REQ-026 rx_in low for 3 cycles then high -> busy pulses, returns to IDLE, no data_valid, no frame_err, data_out unchanged.
REQ-027 Frame 0x3C with stop bit driven low, then line held low 40 bit times, then high -> exactly one frame_err, data_out unchanged, busy low only after line high; following 0x81 frame received correctly.
REQ-028 rst asserted during data bit 4 of frame 0x99 -> no pulses, data_out=8'h00; next frame 0x42 -> data_out=8'h42.
REQ-029 Loopback with top (start pulse, data_in=8'b10101010) at matching bit rate -> data_out=8'hAA with one data_valid.
